// File: rtl/rom_load_arbiter.sv
// Two-source arbiter for the shared ROM-loader port; one grant per load
// session, round-robin on ties, CPU held in reset while a session is live.
//
// Ports:
//   clk, reset_n                   clock, synchronous active-low reset
//   req[1:0]                       per-source session request (level)
//   grant[1:0]                     registered one-hot grant, 00 = port free
//   src_loader_reset/load/data     per-source loader inputs
//   src_loader_ack/load_received   loader responses, routed to owner only
//   rom_loader_reset/load/data     shared loader outputs (owner mux)
//   rom_loader_ack/load_received   shared loader responses
//   hack_reset                     CPU reset hold, active-high
//   busy                           arbiter not idle
module rom_load_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [1:0]              req,
  output logic [1:0]              grant,
  input  logic [1:0]              src_loader_reset,
  input  logic [1:0]              src_loader_load,
  input  logic [2*DATA_WIDTH-1:0] src_loader_data,
  output logic [1:0]              src_loader_ack,
  output logic [1:0]              src_loader_load_received,
  output logic                    rom_loader_reset,
  output logic                    rom_loader_load,
  output logic [DATA_WIDTH-1:0]   rom_loader_data,
  input  logic                    rom_loader_ack,
  input  logic                    rom_loader_load_received,
  output logic                    hack_reset,
  output logic                    busy
);

  localparam int DW = DATA_WIDTH;
  localparam int CW =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] GUARD_LOAD =
    CW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t        state;
  logic          last_owner;
  logic [CW-1:0] guard_cnt;
  logic          owner;
  logic [1:0]    pick;

  // grant is one-hot while in GRANT, so bit 1 names the owner
  assign owner = grant[1];

  // on a tie the source that did not own the last session wins
  always_comb begin
    pick = req;
    if (req == 2'b11)
      pick = last_owner ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      guard_cnt  <= '0;
      hack_reset <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          hack_reset <= |req;
          if (|req) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[owner]) begin
            grant      <= 2'b00;
            last_owner <= owner;
            guard_cnt  <= GUARD_LOAD;
            state      <= GUARD;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state <= IDLE;
            // a pending request keeps the CPU held through the idle hop
            hack_reset <= |req;
          end else begin
            guard_cnt <= guard_cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          grant      <= 2'b00;
          hack_reset <= 1'b1;
        end
      endcase
    end
  end

  // zero-latency owner mux; grant is 00 outside GRANT so all gate to 0
  assign rom_loader_reset = |(grant & src_loader_reset);
  assign rom_loader_load  = |(grant & src_loader_load);
  assign rom_loader_data  =
      ({DW{grant[0]}} & src_loader_data[0  +: DW])
    | ({DW{grant[1]}} & src_loader_data[DW +: DW]);

  assign src_loader_ack           = grant & {2{rom_loader_ack}};
  assign src_loader_load_received =
    grant & {2{rom_loader_load_received}};

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter.
// Inputs change 1ns after posedge; outputs checked before the next edge.
module tb_rom_load_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req;
  logic [1:0]    grant;
  logic [1:0]    src_loader_reset;
  logic [1:0]    src_loader_load;
  logic [2*DW-1:0] src_loader_data;
  logic [1:0]    src_loader_ack;
  logic [1:0]    src_loader_load_received;
  logic          rom_loader_reset;
  logic          rom_loader_load;
  logic [DW-1:0] rom_loader_data;
  logic          rom_loader_ack;
  logic          rom_loader_load_received;
  logic          hack_reset;
  logic          busy;

  int checks = 0;
  int errors = 0;

  rom_load_arbiter #(
    .DATA_WIDTH(DW),
    .GUARD_CYCLES(4)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .req                     (req),
    .grant                   (grant),
    .src_loader_reset        (src_loader_reset),
    .src_loader_load         (src_loader_load),
    .src_loader_data         (src_loader_data),
    .src_loader_ack          (src_loader_ack),
    .src_loader_load_received(src_loader_load_received),
    .rom_loader_reset        (rom_loader_reset),
    .rom_loader_load         (rom_loader_load),
    .rom_loader_data         (rom_loader_data),
    .rom_loader_ack          (rom_loader_ack),
    .rom_loader_load_received(rom_loader_load_received),
    .hack_reset              (hack_reset),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rreset"}, 32'(rom_loader_reset), 32'd0);
    chk({tag, "_rload"},  32'(rom_loader_load),  32'd0);
    chk({tag, "_rdata"},  32'(rom_loader_data),  32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    req = 2'b00;
    src_loader_reset = 2'b00;
    src_loader_load = 2'b00;
    src_loader_data = '0;
    rom_loader_ack = 1'b0;
    rom_loader_load_received = 1'b0;

    // 1: reset state
    step();
    step();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_hack", 32'(hack_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_idle_outs("rst");
    reset_n = 1'b1;
    step();
    chk("rel_hack", 32'(hack_reset), 32'd0);
    chk("rel_grant", 32'(grant), 32'd0);

    // 2: single request from source 0
    req = 2'b01;
    src_loader_data = {16'h1234, 16'hA5C3};
    #1;
    chk("t2_pre_grant", 32'(grant), 32'd0);
    step();
    chk("t2_grant", 32'(grant), 32'h1);
    chk("t2_hack", 32'(hack_reset), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_data", 32'(rom_loader_data), 32'hA5C3);
    rom_loader_ack = 1'b1;
    #1;
    chk("t2_ack", 32'(src_loader_ack), 32'h1);
    rom_loader_ack = 1'b0;
    rom_loader_load_received = 1'b1;
    src_loader_load = 2'b01;
    #1;
    chk("t2_lr", 32'(src_loader_load_received), 32'h1);
    chk("t2_load", 32'(rom_loader_load), 32'd1);
    rom_loader_load_received = 1'b0;
    src_loader_load = 2'b00;
    req = 2'b00;
    step();
    chk("t2_guard_grant", 32'(grant), 32'd0);
    chk_idle_outs("t2_guard");
    step();
    step();
    step();
    chk("t2_guard_end_hack", 32'(hack_reset), 32'd1);
    chk("t2_guard_end_busy", 32'(busy), 32'd1);
    step();
    chk("t2_idle_hack", 32'(hack_reset), 32'd0);
    chk("t2_idle_busy", 32'(busy), 32'd0);

    // 3: tie out of reset goes to source 0, then guard, idle, source 1
    reset_n = 1'b0;
    step();
    req = 2'b11;
    reset_n = 1'b1;
    step();
    chk("t3_tie_grant", 32'(grant), 32'h1);
    req = 2'b10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_guard%0d_grant", i), 32'(grant), 32'd0);
      chk($sformatf("t3_guard%0d_hack", i),
          32'(hack_reset), 32'd1);
      chk($sformatf("t3_guard%0d_data", i),
          32'(rom_loader_data), 32'd0);
    end
    step();
    chk("t3_idle_grant", 32'(grant), 32'd0);
    chk("t3_idle_hack", 32'(hack_reset), 32'd1);
    chk("t3_idle_busy", 32'(busy), 32'd0);
    step();
    chk("t3_grant1", 32'(grant), 32'h2);
    chk("t3_data1", 32'(rom_loader_data), 32'h1234);

    // 4: source 1 finishes, next tie goes to source 0
    req = 2'b00;
    repeat (5) step();
    chk("t4_hack_low", 32'(hack_reset), 32'd0);
    req = 2'b11;
    step();
    chk("t4_rr_grant", 32'(grant), 32'h1);

    // 5: non-owner strobes are ignored
    src_loader_load = 2'b10;
    src_loader_reset = 2'b10;
    rom_loader_load_received = 1'b1;
    rom_loader_ack = 1'b1;
    #1;
    chk("t5_rload", 32'(rom_loader_load), 32'd0);
    chk("t5_rreset", 32'(rom_loader_reset), 32'd0);
    chk("t5_lr", 32'(src_loader_load_received), 32'h1);
    chk("t5_ack", 32'(src_loader_ack), 32'h1);
    src_loader_load = 2'b01;
    src_loader_reset = 2'b01;
    #1;
    chk("t5_own_load", 32'(rom_loader_load), 32'd1);
    chk("t5_own_reset", 32'(rom_loader_reset), 32'd1);
    src_loader_load = 2'b00;
    src_loader_reset = 2'b00;
    rom_loader_load_received = 1'b0;
    rom_loader_ack = 1'b0;
    req = 2'b10;
    repeat (5) step();
    chk("t5_wait_grant", 32'(grant), 32'd0);
    step();
    chk("t5_grant1", 32'(grant), 32'h2);

    // 6: reset mid-session
    reset_n = 1'b0;
    req = 2'b11;
    step();
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_hack", 32'(hack_reset), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk_idle_outs("t6");
    reset_n = 1'b1;
    step();
    chk("t6_regrant", 32'(grant), 32'h1);
    chk("t6_rehack", 32'(hack_reset), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
